// File: rtl/entropy_pkg.sv
// entropy_pkg: shared types and constants for the entropy scheduler slice.
//   prime_state_t       : priming FSM state (PRIMING -> PRIMED, terminal)
//   LFSR_TAPS_16        : Galois LFSR feedback taps for a 16-bit idle mixer
//   PRIME_WORDS_DEFAULT : default number of accepted words before priming
//   ptr_width()         : round-robin pointer width, never below 1 bit
//   lfsr_taps()         : tap constant selected by LFSR width
package entropy_pkg;

    typedef enum logic {
        PRIMING = 1'b0,
        PRIMED  = 1'b1
    } prime_state_t;

    localparam logic [15:0] LFSR_TAPS_16        = 16'hB400;
    localparam int unsigned PRIME_WORDS_DEFAULT = 8;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Only the 16-bit pool width has a characterised tap set; other widths
    // fall back to an MSB-plus-LSB feedback that still never locks at zero.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        logic [31:0] t;
        if (w == 16) begin
            t = {16'h0000, LFSR_TAPS_16};
        end else begin
            t = (32'h1 << (w - 1)) | 32'h1;
        end
        return t;
    endfunction

endpackage

// File: rtl/entropy_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   ptr    : index searched first (the pointer register lives in the parent)
//   valid  : per-requester request
//   grant  : one-hot grant to the first valid requester at or after ptr,
//            all zero when nothing is valid
//   winner : index of the granted requester (0 when none)
module rr_arbiter
    import entropy_pkg::*;
#(
    parameter int unsigned NSRC = 4
) (
    input  logic [ptr_width(NSRC)-1:0] ptr,
    input  logic [NSRC-1:0]            valid,
    output logic [NSRC-1:0]            grant,
    output logic [ptr_width(NSRC)-1:0] winner
);

    localparam int unsigned PW = ptr_width(NSRC);

    logic          found;
    logic [PW:0]   cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            // Wrap by explicit compare so non-power-of-two NSRC stays in range
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand > (PW+1)'(NSRC - 1)) begin
                cand = cand - (PW+1)'(NSRC);
            end
            if (!found && valid[cand[PW-1:0]]) begin
                found                 = 1'b1;
                grant[cand[PW-1:0]]   = 1'b1;
                winner                = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/entropy_sched.sv
// entropy_sched: round-robin scheduler sharing the entropy pool's single
// word-injection input among NSRC sources, plus a priming tracker.
//   clk, rst_n   : clock; synchronous active-low reset
//   src_valid    : per-source word valid
//   src_word     : source words, source i at [i*WIDTH +: WIDTH]
//   src_ready    : per-source grant (one-hot or zero, forced 0 in reset)
//   e_word       : registered word to the pool (one cycle after transfer)
//   pool_primed  : high once PRIME_WORDS words accepted since reset
//   mix_active   : high when e_word carries an accepted word
// Optional: define ENTROPY_SCHED_IDLE_MIX_EN to inject a free-running
// Galois LFSR value on idle cycles instead of zero.
module entropy_sched
    import entropy_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NSRC        = 4,
    parameter int unsigned PRIME_WORDS = PRIME_WORDS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC*WIDTH-1:0]   src_word,
    output logic [NSRC-1:0]         src_ready,
    output logic [WIDTH-1:0]        e_word,
    output logic                    pool_primed,
    output logic                    mix_active
);

    localparam int unsigned PW           = ptr_width(NSRC);
    localparam logic [7:0]  PRIME_TARGET = 8'(PRIME_WORDS);
    localparam logic [PW-1:0] LAST_IDX   = PW'(NSRC - 1);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic [NSRC-1:0]  grant;
    logic             xfer;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] idle_word;
    logic [7:0]       prime_cnt;
    prime_state_t     state;

    rr_arbiter #(
        .NSRC (NSRC)
    ) u_arb (
        .ptr    (ptr),
        .valid  (src_valid),
        .grant  (grant),
        .winner (winner)
    );

    assign src_ready = rst_n ? grant : '0;
    assign xfer      = |(src_valid & src_ready);

    // Grant is one-hot, so a priority-free select is sufficient
    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                sel_word = src_word[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ENTROPY_SCHED_IDLE_MIX_EN
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= WIDTH'(1);
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        end
    end

    assign idle_word = lfsr;
`else
    assign idle_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            e_word      <= '0;
            mix_active  <= 1'b0;
            prime_cnt   <= '0;
            pool_primed <= 1'b0;
            state       <= PRIMING;
        end else begin
            if (xfer) begin
                ptr        <= (winner == LAST_IDX) ? '0 : winner + PW'(1);
                e_word     <= sel_word;
                mix_active <= 1'b1;
            end else begin
                e_word     <= idle_word;
                mix_active <= 1'b0;
            end

            case (state)
                PRIMING: begin
                    if (xfer) begin
                        prime_cnt <= prime_cnt + 8'd1;
                        // Registered flag rises with the PRIME_WORDS-th word on e_word
                        if (prime_cnt + 8'd1 == PRIME_TARGET) begin
                            state       <= PRIMED;
                            pool_primed <= 1'b1;
                        end
                    end
                end
                PRIMED: begin
                    pool_primed <= 1'b1;
                end
                default: begin
                    state <= PRIMING;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entropy_sched.sv
module tb_entropy_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  src_valid;
    logic [63:0] src_word;
    logic [3:0]  src_ready;
    logic [15:0] e_word;
    logic        pool_primed;
    logic        mix_active;

    int checks   = 0;
    int failures = 0;

    logic [15:0] lfsr_m;
    logic [15:0] idle_exp;

    entropy_sched #(
        .WIDTH       (16),
        .NSRC        (4),
        .PRIME_WORDS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_word    (src_word),
        .src_ready   (src_ready),
        .e_word      (e_word),
        .pool_primed (pool_primed),
        .mix_active  (mix_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected idle word: zero by default, free-running LFSR when mixing is on
    always @(posedge clk) begin
        if (!rst_n) begin
            lfsr_m   <= 16'h0001;
            idle_exp <= 16'h0000;
        end else begin
            lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
`ifdef ENTROPY_SCHED_IDLE_MIX_EN
            idle_exp <= lfsr_m;
`else
            idle_exp <= 16'h0000;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int unsigned i, input logic [15:0] w);
        src_word[i*16 +: 16] = w;
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned n);
        rst_n = 1'b0;
        repeat (n) next_cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        src_valid = 4'b1111;
        src_word  = '0;

        // Reset: ready forced low even with all sources valid
        next_cyc();
        #1 chk("rst_ready", 32'(src_ready), 32'h0);
        next_cyc();
        next_cyc();
        chk("rst_eword", 32'(e_word), 32'h0);
        chk("rst_mix", 32'(mix_active), 32'h0);
        chk("rst_primed", 32'(pool_primed), 32'h0);

        // Idle after release
        src_valid = 4'b0000;
        rst_n     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("idle_ready", 32'(src_ready), 32'h0);
            next_cyc();
            chk("idle_eword", 32'(e_word), 32'(idle_exp));
            chk("idle_mix", 32'(mix_active), 32'h0);
            chk("idle_primed", 32'(pool_primed), 32'h0);
        end

        // Priming: 4 transfers from mixed sources with idle gaps
        set_word(0, 16'h2222); set_word(1, 16'h1111);
        set_word(2, 16'h4444); set_word(3, 16'h3333);
        src_valid = 4'b0010;
        #1 chk("pr1_ready", 32'(src_ready), 32'b0010);
        next_cyc();
        chk("pr1_eword", 32'(e_word), 32'h1111);
        chk("pr1_mix", 32'(mix_active), 32'h1);
        chk("pr1_primed", 32'(pool_primed), 32'h0);
        src_valid = 4'b0000;
        next_cyc();
        chk("pr_gap1_mix", 32'(mix_active), 32'h0);
        chk("pr_gap1_eword", 32'(e_word), 32'(idle_exp));
        src_valid = 4'b1001;                       // ptr=2: order 2,3,0,1
        #1 chk("pr2_ready", 32'(src_ready), 32'b1000);
        next_cyc();
        chk("pr2_eword", 32'(e_word), 32'h3333);
        chk("pr2_primed", 32'(pool_primed), 32'h0);
        src_valid = 4'b0001;
        #1 chk("pr3_ready", 32'(src_ready), 32'b0001);
        next_cyc();
        chk("pr3_eword", 32'(e_word), 32'h2222);
        chk("pr3_primed", 32'(pool_primed), 32'h0);
        src_valid = 4'b0000;
        next_cyc();
        chk("pr_gap2_primed", 32'(pool_primed), 32'h0);
        src_valid = 4'b0100;
        #1 chk("pr4_ready", 32'(src_ready), 32'b0100);
        next_cyc();
        chk("pr4_eword", 32'(e_word), 32'h4444);
        chk("pr4_mix", 32'(mix_active), 32'h1);
        chk("pr4_primed", 32'(pool_primed), 32'h1);
        set_word(2, 16'h5555);
        next_cyc();
        chk("pr5_eword", 32'(e_word), 32'h5555);
        chk("pr5_primed", 32'(pool_primed), 32'h1);
        src_valid = 4'b0000;
        next_cyc();
        chk("pr_idle_primed", 32'(pool_primed), 32'h1);
        chk("pr_idle_mix", 32'(mix_active), 32'h0);

        // Single source, lone requester granted every cycle
        do_reset(2);
        chk("rst2_primed", 32'(pool_primed), 32'h0);
        set_word(2, 16'hA5A5);
        src_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1 chk("single_ready", 32'(src_ready), 32'b0100);
            next_cyc();
            chk("single_eword", 32'(e_word), 32'hA5A5);
            chk("single_mix", 32'(mix_active), 32'h1);
        end

        // Wrap: ptr=3 with sources 3 and 0 -> 3 then 0, then ptr=1
        set_word(3, 16'hBBBB); set_word(0, 16'hAAAA); set_word(1, 16'hCCCC);
        src_valid = 4'b1001;
        #1 chk("wrap_ready3", 32'(src_ready), 32'b1000);
        next_cyc();
        chk("wrap_eword3", 32'(e_word), 32'hBBBB);
        src_valid = 4'b0001;
        #1 chk("wrap_ready0", 32'(src_ready), 32'b0001);
        next_cyc();
        chk("wrap_eword0", 32'(e_word), 32'hAAAA);
        src_valid = 4'b0011;
        #1 chk("wrap_ptr1", 32'(src_ready), 32'b0010);
        next_cyc();
        chk("wrap_eword1", 32'(e_word), 32'hCCCC);

        // Fairness: all valid, grants rotate 0,1,2,3,0,1
        do_reset(2);
        for (int unsigned i = 0; i < 4; i++) set_word(i, 16'(i + 1));
        src_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1 chk("fair_ready", 32'(src_ready), 32'(4'b0001 << (k % 4)));
            next_cyc();
            chk("fair_eword", 32'(e_word), 32'((k % 4) + 1));
            chk("fair_mix", 32'(mix_active), 32'h1);
        end
        chk("fair_primed", 32'(pool_primed), 32'h1);

        // Mid-run reset the cycle after a transfer
        rst_n = 1'b0;
        #1 chk("mid_ready", 32'(src_ready), 32'h0);
        next_cyc();
        chk("mid_eword", 32'(e_word), 32'h0);
        chk("mid_mix", 32'(mix_active), 32'h0);
        chk("mid_primed", 32'(pool_primed), 32'h0);
        rst_n     = 1'b1;
        src_valid = 4'b0000;
        next_cyc();
        chk("mid_idle_eword", 32'(e_word), 32'(idle_exp));
`ifdef ENTROPY_SCHED_IDLE_MIX_EN
        chk("mid_idle_seed", 32'(e_word), 32'h0001);
`endif
        src_valid = 4'b0110;
        #1 chk("mid_first_grant", 32'(src_ready), 32'b0010);
        next_cyc();
        chk("mid_first_eword", 32'(e_word), 32'h0002);
        chk("mid_first_primed", 32'(pool_primed), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/entropy_sched.md
Name: entropy_sched

Overview:
- Round-robin scheduler that shares the entropy pool's single word-injection input among NSRC entropy sources (IO samplers, timer jitter, PRNG feedback).
- Each cycle it grants at most one valid source and drives that source's word, registered, onto the pool's e_word input. Idle cycles inject zero.
- Tracks how many words have been mixed since reset and raises pool_primed, so PRNG consumers hold off until the pool has absorbed enough entropy.

Parameters:
- WIDTH, 16, word width; equals the pool's e_word width.
- NSRC, 4, number of requesting sources (2..16).
- PRIME_WORDS, 8, number of accepted words required before pool_primed asserts (1..255).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- src_valid  input  NSRC  per-source word-valid
- src_word  input  NSRC*WIDTH  source words; source i occupies bits [i*WIDTH +: WIDTH]
- src_ready  output  NSRC  per-source grant; one-hot or zero
- e_word  output  WIDTH  word to the entropy pool's injection input
- pool_primed  output  1  high once PRIME_WORDS words have been accepted since reset
- mix_active  output  1  high in cycles where e_word carries an accepted word

Behaviour:
- Reset (rst_n low at posedge):
  - e_word=0, mix_active=0, pool_primed=0.
  - Round-robin pointer ptr=0, prime counter=0, FSM=PRIMING.
  - src_ready is combinational and forced to 0 while rst_n is low.
- Arbitration (combinational):
  - Winner = first i in the order ptr, ptr+1, …, wrapping mod NSRC, with src_valid[i]=1.
  - src_ready[winner]=1; all other bits 0. No valid source gives src_ready=0.
- Handshake:
  - A transfer occurs when src_valid[i] & src_ready[i].
  - A source holds valid and word stable until it sees ready. It may drop valid without a transfer (no penalty).
  - A source may not depend on ready to assert valid.
- Pointer:
  - On a transfer from source i, ptr <= (i+1) mod NSRC. Wrap: i=NSRC-1 gives ptr=0.
  - With no transfer, ptr holds.
  - A continuously valid source therefore gets at most one of every NSRC grants when others compete. A lone requester is granted every cycle.
- Datapath, latency 1:
  - Cycle after a transfer: e_word = accepted word, mix_active=1.
  - Otherwise: e_word=0, mix_active=0. Zero is neutral for the pool's XOR.
- FSM:
  - PRIMING: the counter increments on each transfer. When a transfer brings the count to PRIME_WORDS, next state is PRIMED.
  - PRIMED: pool_primed=1. Counter frozen (saturated); state is terminal until reset.
  - pool_primed is registered and rises in the same cycle e_word carries the PRIME_WORDS-th word.
- Arithmetic:
  - Counter width is 8 bits and never wraps.
  - ptr width is clog2(NSRC), minimum 1.
  - Modulo for non-power-of-two NSRC is an explicit compare to NSRC-1, not bit truncation.
- Reset mid-operation: any in-flight word is dropped (e_word=0 next cycle), priming restarts from 0, and ptr returns to 0.

Optional Feature:
- Macro: ENTROPY_SCHED_IDLE_MIX_EN.
- Defined:
  - A WIDTH-bit Galois LFSR (seed 1 at reset, taps from a package constant for WIDTH=16) advances every cycle.
  - On cycles with no transfer, e_word carries the LFSR value instead of 0. mix_active stays 0.
  - Idle words do not count toward priming.
- Undefined: idle e_word is 0, and no LFSR is instantiated.

Decomposition:
- Package entropy_pkg:
  - FSM state enum {PRIMING, PRIMED}.
  - LFSR tap constant for WIDTH=16 (16'hB400).
  - PRIME_WORDS default.
- One sub-module: rr_arbiter (NSRC, ptr in, valid in, one-hot grant out, winner index out). It is purely combinational, and the pointer register stays in entropy_sched.

Test Plan:
- Reset/idle: NSRC=4, WIDTH=16, PRIME_WORDS=4; hold rst_n=0 for 3 cycles, then all valid=0 for 5 cycles -> src_ready=0, e_word=0, mix_active=0 and pool_primed=0 throughout.
- Single source: src_valid=4'b0100, word 16'hA5A5, held 3 cycles -> src_ready[2]=1 each cycle; e_word=16'hA5A5 with mix_active=1 in each following cycle; ptr=3 after.
- Fairness: all 4 valid continuously, words 16'h0001..16'h0004 -> grant order 0,1,2,3,0,1…; e_word sequence 1,2,3,4,1,2 lagging grants by one cycle.
- Wrap: ptr=3 with src_valid=4'b1001 -> grant 3 then 0, ptr ends at 1.
- Priming: 4 transfers from mixed sources with idle gaps -> pool_primed rises exactly in the cycle e_word shows the 4th word; further transfers leave it high.
- Mid-run reset: rst_n=0 on the cycle after a transfer -> next e_word=0, pool_primed=0, and the first grant after release goes to the lowest valid index. With ENTROPY_SCHED_IDLE_MIX_EN defined, idle e_word is 16'h0001 then follows the LFSR sequence.
